// File: rtl/bram16k_arbiter.sv
// Round-robin arbiter sharing one 512x32 dual-port bram16k between two requesters.
// Read and write ports are arbitrated independently; read data is routed back by requester id.
module bram16k_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_req0_valid,
  input  logic                  i_req0_we,
  input  logic [ADDR_WIDTH-1:0] i_req0_addr,
  input  logic [DATA_WIDTH-1:0] i_req0_wdata,
  output logic                  o_req0_ready,
  output logic                  o_req0_rvalid,
  output logic [DATA_WIDTH-1:0] o_req0_rdata,
  input  logic                  i_req1_valid,
  input  logic                  i_req1_we,
  input  logic [ADDR_WIDTH-1:0] i_req1_addr,
  input  logic [DATA_WIDTH-1:0] i_req1_wdata,
  output logic                  o_req1_ready,
  output logic                  o_req1_rvalid,
  output logic [DATA_WIDTH-1:0] o_req1_rdata,
  output logic [DATA_WIDTH-1:0] o_bram_data,
  output logic [ADDR_WIDTH-1:0] o_bram_rdaddress,
  output logic [ADDR_WIDTH-1:0] o_bram_wraddress,
  output logic                  o_bram_wren,
  input  logic [DATA_WIDTH-1:0] i_bram_q
);

  localparam int unsigned LAST = RD_LATENCY - 1;

  logic                  w_wr0, w_wr1, w_rd0, w_rd1;
  logic                  w_wr_any, w_rd_any;
  logic                  w_wr_win, w_rd_win;
  logic                  w_collide, w_rd_gnt;
  logic [ADDR_WIDTH-1:0] w_wr_addr, w_rd_addr;
  logic [DATA_WIDTH-1:0] w_wr_data;

  logic                  r_wr_prio, r_rd_prio;
  logic [ADDR_WIDTH-1:0] r_wraddr, r_rdaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [RD_LATENCY-1:0] r_pipe_v, r_pipe_id;

  // Port classification; reset masks every request so nothing is granted.
  always_comb begin
    w_wr0 = i_req0_valid &  i_req0_we & ~i_reset;
    w_wr1 = i_req1_valid &  i_req1_we & ~i_reset;
    w_rd0 = i_req0_valid & ~i_req0_we & ~i_reset;
    w_rd1 = i_req1_valid & ~i_req1_we & ~i_reset;
  end

  // Winner id: priority register breaks ties, otherwise the sole contender.
  always_comb begin
    w_wr_any  = w_wr0 | w_wr1;
    w_rd_any  = w_rd0 | w_rd1;
    w_wr_win  = (w_wr0 & w_wr1) ? r_wr_prio : w_wr1;
    w_rd_win  = (w_rd0 & w_rd1) ? r_rd_prio : w_rd1;
    w_wr_addr = w_wr_win ? i_req1_addr  : i_req0_addr;
    w_wr_data = w_wr_win ? i_req1_wdata : i_req0_wdata;
    w_rd_addr = w_rd_win ? i_req1_addr  : i_req0_addr;
    // A read of the address being written this cycle waits one cycle for the new data.
    w_collide = w_wr_any & w_rd_any & (w_rd_addr == w_wr_addr);
    w_rd_gnt  = w_rd_any & ~w_collide;
  end

  assign o_req0_ready = (w_wr_any & ~w_wr_win) | (w_rd_gnt & ~w_rd_win);
  assign o_req1_ready = (w_wr_any &  w_wr_win) | (w_rd_gnt &  w_rd_win);

  assign o_bram_wren      = w_wr_any;
  assign o_bram_wraddress = w_wr_any ? w_wr_addr : r_wraddr;
  assign o_bram_data      = w_wr_any ? w_wr_data : r_wdata;
  assign o_bram_rdaddress = w_rd_gnt ? w_rd_addr : r_rdaddr;

  assign o_req0_rdata  = i_bram_q;
  assign o_req1_rdata  = i_bram_q;
  assign o_req0_rvalid = r_pipe_v[LAST] & ~r_pipe_id[LAST] & ~i_reset;
  assign o_req1_rvalid = r_pipe_v[LAST] &  r_pipe_id[LAST] & ~i_reset;

  // Priorities, held bram address/data and the read-return pipeline.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_prio <= 1'b0;
      r_rd_prio <= 1'b0;
      r_wraddr  <= '0;
      r_wdata   <= '0;
      r_rdaddr  <= '0;
      r_pipe_v  <= '0;
      r_pipe_id <= '0;
    end else begin
      if (w_wr_any) begin
        r_wr_prio <= ~w_wr_win;
        r_wraddr  <= w_wr_addr;
        r_wdata   <= w_wr_data;
      end
      if (w_rd_gnt) begin
        r_rd_prio <= ~w_rd_win;
        r_rdaddr  <= w_rd_addr;
      end
      r_pipe_v[0]  <= w_rd_gnt;
      r_pipe_id[0] <= w_rd_win;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        r_pipe_v[i]  <= r_pipe_v[i-1];
        r_pipe_id[i] <= r_pipe_id[i-1];
      end
    end
  end

endmodule

// File: tb/tb_bram16k_arbiter.sv
// Scoreboard bench for bram16k_arbiter: directed scenarios then randomized traffic,
// checked against a memory-and-fairness reference model and a behavioural bram16k.
module tb_bram16k_arbiter;

  localparam int RD_LATENCY = 1;

  typedef struct {
    logic        id;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req0_we = 1'b0;
  logic [8:0]  req0_addr = '0;
  logic [31:0] req0_wdata = '0;
  logic        req0_ready, req0_rvalid;
  logic [31:0] req0_rdata;
  logic        req1_valid = 1'b0, req1_we = 1'b0;
  logic [8:0]  req1_addr = '0;
  logic [31:0] req1_wdata = '0;
  logic        req1_ready, req1_rvalid;
  logic [31:0] req1_rdata;
  logic [31:0] bram_data, bram_q;
  logic [8:0]  bram_rdaddress, bram_wraddress;
  logic        bram_wren;

  logic        mem_clear = 1'b1;
  logic [31:0] mem [512];

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  exp_t        sb [$];

  // Reference model state
  logic [31:0] ref_mem [512];
  bit          m_wr_fav = 1'b0, m_rd_fav = 1'b0;
  logic [8:0]  m_wraddr = '0, m_rdaddr = '0;
  logic [31:0] m_wdata = '0;

  bram16k_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .RD_LATENCY(RD_LATENCY)) dut (
    .i_clock(clk), .i_reset(reset),
    .i_req0_valid(req0_valid), .i_req0_we(req0_we), .i_req0_addr(req0_addr),
    .i_req0_wdata(req0_wdata), .o_req0_ready(req0_ready), .o_req0_rvalid(req0_rvalid),
    .o_req0_rdata(req0_rdata),
    .i_req1_valid(req1_valid), .i_req1_we(req1_we), .i_req1_addr(req1_addr),
    .i_req1_wdata(req1_wdata), .o_req1_ready(req1_ready), .o_req1_rvalid(req1_rvalid),
    .o_req1_rdata(req1_rdata),
    .o_bram_data(bram_data), .o_bram_rdaddress(bram_rdaddress),
    .o_bram_wraddress(bram_wraddress), .o_bram_wren(bram_wren), .i_bram_q(bram_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural bram16k with one-cycle registered read
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 512; i++) mem[i] <= '0;
    end else if (bram_wren) begin
      mem[bram_wraddress] <= bram_data;
    end
    bram_q <= mem[bram_rdaddress];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Apply one cycle of stimulus and check the combinational handshake against the model.
  task automatic drive(input bit v0, input bit we0, input logic [8:0] a0, input logic [31:0] d0,
                       input bit v1, input bit we1, input logic [8:0] a1, input logic [31:0] d1,
                       input bit rst);
    bit          w0, w1, r0, r1, wg, rg, ww, rw, e0, e1;
    logic [8:0]  wa, ra;
    logic [31:0] wd;
    @(negedge clk);
    reset = rst;
    req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
    #2;
    if (rst) begin
      check("reset_ready0", 32'(req0_ready), 32'(0));
      check("reset_ready1", 32'(req1_ready), 32'(0));
      check("reset_wren", 32'(bram_wren), 32'(0));
      sb.delete();
      m_wr_fav = 1'b0; m_rd_fav = 1'b0;
      m_wraddr = '0; m_wdata = '0; m_rdaddr = '0;
    end else begin
      w0 = v0 && we0;  w1 = v1 && we1;
      r0 = v0 && !we0; r1 = v1 && !we1;
      wg = w0 || w1;
      ww = (w0 && w1) ? m_wr_fav : w1;
      wa = ww ? a1 : a0;
      wd = ww ? d1 : d0;
      rw = (r0 && r1) ? m_rd_fav : r1;
      ra = rw ? a1 : a0;
      rg = (r0 || r1) && !(wg && ra == wa);
      e0 = (wg && !ww) || (rg && !rw);
      e1 = (wg && ww) || (rg && rw);
      check("ready0", 32'(req0_ready), 32'(e0));
      check("ready1", 32'(req1_ready), 32'(e1));
      check("wren", 32'(bram_wren), 32'(wg));
      check("wraddress", 32'(bram_wraddress), 32'(wg ? wa : m_wraddr));
      check("wdata", bram_data, wg ? wd : m_wdata);
      check("rdaddress", 32'(bram_rdaddress), 32'(rg ? ra : m_rdaddr));
      if (rg) begin
        sb.push_back('{id: rw, data: ref_mem[ra], due: cyc + RD_LATENCY});
        m_rd_fav = !rw;
        m_rdaddr = ra;
      end
      if (wg) begin
        ref_mem[wa] = wd;
        m_wr_fav = !ww;
        m_wraddr = wa;
        m_wdata = wd;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, '0, '0, 0, 0, '0, '0, 0);
  endtask

  // Response monitor: pops the scoreboard whenever a read result is presented.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (req0_rvalid && req1_rvalid) begin
        n_tests++; n_fail++;
        $display("FAIL rvalid_both: both rvalid high (cycle %0d)", cyc);
      end
      if (req0_rvalid || req1_rvalid) begin
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rvalid_spurious: rvalid0=%0b rvalid1=%0b with nothing outstanding (cycle %0d)",
                   req0_rvalid, req1_rvalid, cyc);
        end else begin
          e = sb.pop_front();
          check("rvalid_id", 32'(req1_rvalid), 32'(e.id));
          check("rdata", e.id ? req1_rdata : req0_rdata, e.data);
          check("rvalid_cycle", 32'(cyc), 32'(e.due));
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        n_tests++; n_fail++;
        $display("FAIL rvalid_missing: no rvalid for req%0d data %h due cycle %0d (cycle %0d)",
                 e.id, e.data, e.due, cyc);
      end
    end
  end

  initial begin
    bit          v0, we0, v1, we1, rst;
    logic [8:0]  a0, a1;
    logic [31:0] d0, d1;
    for (int i = 0; i < 512; i++) ref_mem[i] = '0;

    // Reset with requests present; memory cleared meanwhile
    drive(1, 1, 9'h001, 32'h1, 1, 0, 9'h002, 32'h0, 1);
    drive(1, 0, 9'h003, 32'h0, 1, 1, 9'h004, 32'h2, 1);
    mem_clear = 1'b0;
    idle(1);

    // Single write then read
    drive(1, 1, 9'h005, 32'hDEADBEEF, 0, 0, '0, '0, 0);
    drive(1, 0, 9'h005, 32'h0, 0, 0, '0, '0, 0);
    idle(3);

    // Write contention after reset, then readback
    drive(0, 0, '0, '0, 0, 0, '0, '0, 1);
    for (int i = 0; i < 4; i++)
      drive(1, 1, 9'h010, 32'h11111111, 1, 1, 9'h011, 32'h22222222, 0);
    drive(1, 0, 9'h010, 32'h0, 0, 0, '0, '0, 0);
    drive(0, 0, '0, '0, 1, 0, 9'h011, 32'h0, 0);
    idle(2);

    // Preload, then parallel read and write
    drive(1, 1, 9'h1FF, 32'hCAFEF00D, 1, 1, 9'h100, 32'h00000100, 0);
    drive(1, 1, 9'h101, 32'h00000101, 1, 1, 9'h102, 32'h00000102, 0);
    drive(1, 1, 9'h103, 32'h00000103, 0, 0, '0, '0, 0);
    drive(1, 1, 9'h020, 32'h12345678, 1, 0, 9'h1FF, 32'h0, 0);
    idle(2);

    // Write/read collision, read retried next cycle
    drive(1, 1, 9'h030, 32'hA5A5A5A5, 1, 0, 9'h030, 32'h0, 0);
    drive(0, 0, '0, '0, 1, 0, 9'h030, 32'h0, 0);
    idle(2);

    // Read fairness and ordering
    for (int i = 0; i < 8; i++)
      drive(1, 0, 9'h100 + 9'(i % 4), 32'h0, 1, 0, 9'h100 + 9'((i + 1) % 4), 32'h0, 0);
    idle(3);

    // Reset the cycle after a read is accepted
    drive(1, 0, 9'h005, 32'h0, 0, 0, '0, '0, 0);
    drive(1, 0, 9'h101, 32'h0, 1, 1, 9'h040, 32'h77, 1);
    drive(1, 1, 9'h041, 32'h33, 1, 1, 9'h042, 32'h44, 0);
    drive(1, 0, 9'h102, 32'h0, 1, 0, 9'h103, 32'h0, 0);
    idle(3);

    // Randomized traffic over a small address window to provoke collisions
    for (int i = 0; i < 600; i++) begin
      v0  = ($urandom_range(0, 3) != 0);
      we0 = $urandom_range(0, 1) == 1;
      a0  = 9'h1F0 + 9'($urandom_range(0, 15));
      d0  = $urandom;
      v1  = ($urandom_range(0, 3) != 0);
      we1 = $urandom_range(0, 1) == 1;
      a1  = 9'h1F0 + 9'($urandom_range(0, 15));
      d1  = $urandom;
      rst = ($urandom_range(0, 59) == 0);
      drive(v0, we0, a0, d0, v1, we1, a1, d1, rst);
    end
    idle(RD_LATENCY + 3);

    @(negedge clk);
    #6;
    check("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
